me_stage_mem_rsp: RTL and testbench
===================================

# me_stage_mem_rsp

- Parametrised memory-access pipeline stage between EX and WB.
- Holds one instruction and, for loads/stores that issued a split-transaction data-bus request in EX, stalls until the matching `data_ok` response arrives.
- Aligns and extends load data for any access size up to `XLEN`, and publishes forwarding data with a validity flag for load-use hazard detection.
- Tracks in-flight responses orphaned by pipeline flushes and silently discards them, so responses stay matched to their requesters.

## Interface
Parameters:
- `XLEN`, 32: datapath width, 32 or 64.
- `PAYLOAD_W`, 128: opaque pass-through bus width (pc, CSR fields, exception info).
- `MAX_OUTSTANDING`, 2: max data-bus responses in flight, counted from ME's view; ≥1.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `ex_valid` in 1: EX presents an instruction.
- `ex_ready` out 1: ME accepts this cycle (allow-in).
- `ex_payload` in `PAYLOAD_W`: opaque fields.
- `ex_result` in `XLEN`: ALU/CSR result.
- `ex_mem_req` in 1: instruction's bus request was accepted (addr_ok) in EX.
- `ex_is_load` in 1: result comes from memory.
- `ex_ld_size` in 2: load size; 0 = byte, 1 = half, 2 = word, 3 = dword (XLEN=64 only).
- `ex_ld_signed` in 1: sign-extend loaded value.
- `ex_addr_lo` in `$clog2(XLEN/8)`: byte offset within the bus word.
- `ex_gr_we` in 1: register write enable.
- `ex_dest` in 5: destination register.
- `data_ok` in 1: oldest outstanding response valid.
- `rdata` in `XLEN`: response data.
- `req_allow` out 1: EX may issue a new bus request.
- `flush` in 1: kill ME and younger stages.
- `flush_ex_req` in 1: a killed EX instruction had an accepted request; valid only with `flush`.
- `wb_valid` out 1: ME presents an instruction to WB.
- `wb_ready` in 1: WB allow-in.
- `wb_payload` out `PAYLOAD_W`: opaque fields.
- `wb_result` out `XLEN`: final result.
- `wb_gr_we` out 1: register write enable.
- `wb_dest` out 5: destination register.
- `fwd_dest` out 5: `dest` when `me_valid & gr_we`, else 0.
- `fwd_data` out `XLEN`: `final_result` masked by `gr_we`.
- `fwd_data_ok` out 1: 0 while ME holds a load still awaiting its response.

## Operation
- **ME state.** `me_valid`, captured fields, `pending` (a response is owed to the ME instruction), `buf_valid`, `buf_data`, `discard_cnt`.
- **Capture.** On `ex_valid & ex_ready`, ME captures all fields and sets `pending = ex_mem_req`.
- **Response routing.** `data_ok` always belongs to the oldest outstanding request:
  - if `discard_cnt != 0`: decrement `discard_cnt`, drop the data;
  - else if `me_valid & pending`: consume it.
- **Consumed response.**
  - If `wb_ready`, the instruction leaves this cycle using `rdata` directly.
  - Otherwise latch `buf_data = rdata`, set `buf_valid = 1`, clear `pending`.
- **Handshake.**
  - `ready_go = !pending | (data_ok & discard_cnt == 0)`.
  - `wb_valid = me_valid & ready_go`.
  - `ex_ready = !me_valid | (ready_go & wb_ready)`.
- **Raw data select.** `raw = buf_valid ? buf_data : rdata`.
- **Load alignment.**
  - `sh = raw >> (ex_addr_lo * 8)`.
  - Keep the low 8/16/32/`XLEN` bits by size.
  - Extend with zeros, or with the top kept bit when signed.
  - Size 3 with XLEN=32 behaves as size 2.
  - Misaligned offsets are not checked here; EX raises ALE.
- **Final result.** `final_result = is_load ? aligned : result`. Stores (`ex_mem_req & !ex_is_load`) still wait for `data_ok`.
- **Flush.**
  - Clears `me_valid`, `pending` and `buf_valid`.
  - `discard_cnt` next value = current − (1 if this cycle's `data_ok` was discarded) + (`me_valid & pending & !(data_ok consumed)`) + `flush_ex_req`.
  - `flush` has priority over capture: nothing is accepted in a flush cycle.
- **Request limit.** `req_allow = discard_cnt + (me_valid & pending) < MAX_OUTSTANDING`.
- **Counter width and overflow.** `discard_cnt` width is `$clog2(MAX_OUTSTANDING+1)`. Reaching a count above `MAX_OUTSTANDING` is a protocol error, covered by a bench assertion.

## Timing
- **Reset.** `me_valid`, `pending`, `buf_valid`, `discard_cnt` = 0. All outputs 0 except `ex_ready` = 1, `req_allow` = 1, `fwd_data_ok` = 1.
- **Latency.**
  - Non-memory instruction: 1 cycle in ME.
  - Memory instruction: `wb_valid` in the same cycle as its `data_ok` (combinational bypass); minimum 1 cycle.
- **Buffered hold.** Buffered data is held until `wb_ready`; `wb_*` outputs stay stable while `wb_valid & !wb_ready`.
- **Forwarding.** `fwd_data_ok` rises combinationally with the consuming `data_ok`.
- **Reset mid-transaction.** Clears `discard_cnt`; the bus is reset in the same cycle.

## Structure
- **Package `me_pkg`.** Holds the `ld_size_e` enum (`LD_B`, `LD_H`, `LD_W`, `LD_D`) and the `XLEN`-derived offset-width function.
- **Sub-module `me_load_align`.** Combinational: `raw`, `addr_lo`, `size`, `signed` → `aligned`, parametrised by `XLEN`.

## Test plan
- **Byte load, sign-extended.** XLEN=32; `ld.b`, `addr_lo` = 3, signed; `rdata` = 0x80FF_1234, `data_ok` 2 cycles late → `wb_result` = 0xFFFF_FF80. `fwd_data_ok` is 0 for 2 cycles.
- **Dword and unsigned half.** XLEN=64; `ld.d` with `rdata` = 0x0123_4567_89AB_CDEF → same value on `wb_result`. `ld.hu` at `addr_lo` = 6 → 0x0000_0000_0000_0123.
- **WB backpressure.** `data_ok` with `wb_ready` = 0 for 3 cycles, then `rdata` changes to junk → `wb_result` keeps the buffered value; the instruction leaves when `wb_ready` = 1.
- **Flush with orphaned responses.** Flush while ME load pending, with `flush_ex_req` = 1 → `discard_cnt` = 2 and `req_allow` = 0 (MAX=2). The next two `data_ok` are dropped. A new load's response arrives third and is used correctly.
- **Flush coincident with `data_ok`.** `flush` and the consuming `data_ok` in the same cycle → `discard_cnt` stays 0 and no `wb_valid` appears next cycle.
- **Back-to-back ALU instructions.** `wb_ready` = 1 → one instruction per cycle, `ex_ready` constantly 1. Reset asserted mid-stream → `wb_valid` = 0 next cycle.

Source files
------------

// File: rtl/me_stage_mem_rsp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : me_pkg
// Brief    : Shared types and helpers for the memory-response pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
package me_pkg;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    // Width of the byte offset within one XLEN-wide bus word.
    function automatic int off_w(input int xlen);
        return $clog2(xlen / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/me_stage_mem_rsp_if.sv
`default_nettype none
// ============================================================================
// Module   : me_stage_mem_rsp_if
// Brief    : EX->ME, data-bus response, flush and ME->WB signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface me_stage_mem_rsp_if
    import me_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 128
);
    localparam int OFF_W = off_w(XLEN);

    logic                 ex_valid;
    logic                 ex_ready;
    logic [PAYLOAD_W-1:0] ex_payload;
    logic [XLEN-1:0]      ex_result;
    logic                 ex_mem_req;
    logic                 ex_is_load;
    logic [1:0]           ex_ld_size;
    logic                 ex_ld_signed;
    logic [OFF_W-1:0]     ex_addr_lo;
    logic                 ex_gr_we;
    logic [4:0]           ex_dest;
    logic                 data_ok;
    logic [XLEN-1:0]      rdata;
    logic                 req_allow;
    logic                 flush;
    logic                 flush_ex_req;
    logic                 wb_valid;
    logic                 wb_ready;
    logic [PAYLOAD_W-1:0] wb_payload;
    logic [XLEN-1:0]      wb_result;
    logic                 wb_gr_we;
    logic [4:0]           wb_dest;
    logic [4:0]           fwd_dest;
    logic [XLEN-1:0]      fwd_data;
    logic                 fwd_data_ok;

    // Master: the surrounding pipeline and bus. Slave: the ME stage.
    modport master (
        output ex_valid, ex_payload, ex_result, ex_mem_req, ex_is_load,
               ex_ld_size, ex_ld_signed, ex_addr_lo, ex_gr_we, ex_dest,
               data_ok, rdata, flush, flush_ex_req, wb_ready,
        input  ex_ready, req_allow, wb_valid, wb_payload, wb_result,
               wb_gr_we, wb_dest, fwd_dest, fwd_data, fwd_data_ok
    );

    modport slave (
        input  ex_valid, ex_payload, ex_result, ex_mem_req, ex_is_load,
               ex_ld_size, ex_ld_signed, ex_addr_lo, ex_gr_we, ex_dest,
               data_ok, rdata, flush, flush_ex_req, wb_ready,
        output ex_ready, req_allow, wb_valid, wb_payload, wb_result,
               wb_gr_we, wb_dest, fwd_dest, fwd_data, fwd_data_ok
    );

endinterface
`default_nettype wire

// File: rtl/me_load_align.sv
`default_nettype none
// ============================================================================
// Module   : me_load_align
// Brief    : Shifts raw bus data by the byte offset and zero/sign-extends it.
// Revision : 1.0 - initial release
// ============================================================================
module me_load_align
    import me_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = off_w(XLEN)
) (
    input  logic [XLEN-1:0]  raw_i,
    input  logic [OFF_W-1:0] addr_lo_i,
    input  ld_size_e         size_i,
    input  logic             signed_i,
    output logic [XLEN-1:0]  aligned_o
);
    logic [XLEN-1:0] w_sh;
    logic [XLEN-1:0] w_byte;
    logic [XLEN-1:0] w_half;
    logic [XLEN-1:0] w_word;

    assign w_sh   = raw_i >> {addr_lo_i, 3'b000};
    assign w_byte = {{(XLEN-8){signed_i & w_sh[7]}},   w_sh[7:0]};
    assign w_half = {{(XLEN-16){signed_i & w_sh[15]}}, w_sh[15:0]};

    generate
        if (XLEN > 32) begin : g_word_ext
            assign w_word = {{(XLEN-32){signed_i & w_sh[31]}}, w_sh[31:0]};
        end else begin : g_word_full
            assign w_word = w_sh;
        end
    endgenerate

    // A dword request on a 32-bit datapath degrades to a word access.
    always_comb begin
        aligned_o = w_word;
        case (size_i)
            LD_B: aligned_o = w_byte;
            LD_H: aligned_o = w_half;
            LD_W: aligned_o = w_word;
            LD_D: aligned_o = (XLEN > 32) ? w_sh : w_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/me_stage_mem_rsp.sv
`default_nettype none
// ============================================================================
// Module   : me_stage_mem_rsp
// Brief    : ME pipeline stage; waits for split-transaction data responses,
//            aligns loads, forwards results and drops flush-orphaned responses.
// Revision : 1.0 - initial release
// ============================================================================
module me_stage_mem_rsp
    import me_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int PAYLOAD_W       = 128,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic               clk,
    input  logic               reset,
    me_stage_mem_rsp_if.slave  me_if
);
    localparam int OFF_W = off_w(XLEN);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SUM_W = CNT_W + 1;

    logic                 me_valid_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [XLEN-1:0]      result_q;
    logic                 is_load_q;
    ld_size_e             ld_size_q;
    logic                 ld_signed_q;
    logic [OFF_W-1:0]     addr_lo_q;
    logic                 gr_we_q;
    logic [4:0]           dest_q;
    logic                 pending_q;
    logic                 buf_valid_q;
    logic [XLEN-1:0]      buf_data_q;
    logic [CNT_W-1:0]     discard_cnt_q;
    logic [CNT_W-1:0]     discard_cnt_d;

    logic             w_cnt_zero;
    logic             w_discard;
    logic             w_ok_live;
    logic             w_consume;
    logic             w_ready_go;
    logic             w_wb_valid;
    logic             w_ex_ready;
    logic             w_capture;
    logic             w_leave;
    logic             w_orphan;
    logic [SUM_W-1:0] w_owed;
    logic [XLEN-1:0]  w_raw;
    logic [XLEN-1:0]  w_aligned;
    logic [XLEN-1:0]  w_final;

    // A response always belongs to the oldest request; orphans come first.
    assign w_cnt_zero = (discard_cnt_q == '0);
    assign w_discard  = me_if.data_ok & ~w_cnt_zero;
    assign w_ok_live  = me_if.data_ok & w_cnt_zero;
    assign w_consume  = w_ok_live & me_valid_q & pending_q;
    assign w_ready_go = ~pending_q | w_ok_live;
    assign w_wb_valid = me_valid_q & w_ready_go;
    assign w_ex_ready = ~me_valid_q | (w_ready_go & me_if.wb_ready);
    assign w_capture  = me_if.ex_valid & w_ex_ready & ~me_if.flush;
    assign w_leave    = w_wb_valid & me_if.wb_ready;
    assign w_orphan   = me_valid_q & pending_q & ~w_consume;

    always_comb begin
        discard_cnt_d = discard_cnt_q;
        if (w_discard) begin
            discard_cnt_d = discard_cnt_d - CNT_W'(1);
        end
        if (me_if.flush) begin
            if (w_orphan) begin
                discard_cnt_d = discard_cnt_d + CNT_W'(1);
            end
            if (me_if.flush_ex_req) begin
                discard_cnt_d = discard_cnt_d + CNT_W'(1);
            end
        end
    end

    assign w_owed = SUM_W'(discard_cnt_q) + SUM_W'(me_valid_q & pending_q);
    assign w_raw  = buf_valid_q ? buf_data_q : me_if.rdata;

    me_load_align #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_align (
        .raw_i     (w_raw),
        .addr_lo_i (addr_lo_q),
        .size_i    (ld_size_q),
        .signed_i  (ld_signed_q),
        .aligned_o (w_aligned)
    );

    assign w_final = is_load_q ? w_aligned : result_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            me_valid_q    <= 1'b0;
            payload_q     <= '0;
            result_q      <= '0;
            is_load_q     <= 1'b0;
            ld_size_q     <= LD_B;
            ld_signed_q   <= 1'b0;
            addr_lo_q     <= '0;
            gr_we_q       <= 1'b0;
            dest_q        <= '0;
            pending_q     <= 1'b0;
            buf_valid_q   <= 1'b0;
            buf_data_q    <= '0;
            discard_cnt_q <= '0;
        end else begin
            discard_cnt_q <= discard_cnt_d;
            if (me_if.flush) begin
                me_valid_q  <= 1'b0;
                pending_q   <= 1'b0;
                buf_valid_q <= 1'b0;
            end else if (w_capture) begin
                me_valid_q  <= 1'b1;
                payload_q   <= me_if.ex_payload;
                result_q    <= me_if.ex_result;
                is_load_q   <= me_if.ex_is_load;
                ld_size_q   <= ld_size_e'(me_if.ex_ld_size);
                ld_signed_q <= me_if.ex_ld_signed;
                addr_lo_q   <= me_if.ex_addr_lo;
                gr_we_q     <= me_if.ex_gr_we;
                dest_q      <= me_if.ex_dest;
                pending_q   <= me_if.ex_mem_req;
                buf_valid_q <= 1'b0;
            end else if (w_leave) begin
                me_valid_q  <= 1'b0;
                pending_q   <= 1'b0;
                buf_valid_q <= 1'b0;
            end else if (w_consume) begin
                // WB stalled: park the response so the bus may move on.
                buf_valid_q <= 1'b1;
                buf_data_q  <= me_if.rdata;
                pending_q   <= 1'b0;
            end
        end
    end

    assign me_if.ex_ready    = w_ex_ready;
    assign me_if.req_allow   = (w_owed < SUM_W'(MAX_OUTSTANDING));
    assign me_if.wb_valid    = w_wb_valid;
    assign me_if.wb_payload  = payload_q;
    assign me_if.wb_result   = w_final;
    assign me_if.wb_gr_we    = gr_we_q;
    assign me_if.wb_dest     = dest_q;
    assign me_if.fwd_dest    = (me_valid_q & gr_we_q) ? dest_q : 5'd0;
    assign me_if.fwd_data    = gr_we_q ? w_final : '0;
    assign me_if.fwd_data_ok = ~(me_valid_q & is_load_q & ~w_ready_go);

endmodule
`default_nettype wire

// File: tb/tb_me_stage_mem_rsp.sv
`default_nettype none
// ============================================================================
// Module   : tb_me_stage_mem_rsp
// Brief    : Directed self-checking bench for me_stage_mem_rsp (XLEN 32 and 64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_me_stage_mem_rsp;
    localparam int MAX_OUT = 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    me_stage_mem_rsp_if #(.XLEN(32), .PAYLOAD_W(128)) a_if ();
    me_stage_mem_rsp_if #(.XLEN(64), .PAYLOAD_W(128)) b_if ();

    me_stage_mem_rsp #(.XLEN(32), .PAYLOAD_W(128), .MAX_OUTSTANDING(MAX_OUT)) dut32 (
        .clk   (clk),
        .reset (reset),
        .me_if (a_if.slave)
    );

    me_stage_mem_rsp #(.XLEN(64), .PAYLOAD_W(128), .MAX_OUTSTANDING(MAX_OUT)) dut64 (
        .clk   (clk),
        .reset (reset),
        .me_if (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            assert (32'(dut32.discard_cnt_q) <= MAX_OUT)
                else $error("FAIL discard_cnt32 overflow: %0d", dut32.discard_cnt_q);
            assert (32'(dut64.discard_cnt_q) <= MAX_OUT)
                else $error("FAIL discard_cnt64 overflow: %0d", dut64.discard_cnt_q);
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex32(input logic mem, input logic ld, input logic [1:0] sz,
                            input logic sgn, input logic [1:0] lo, input logic we,
                            input logic [4:0] dst, input logic [31:0] res);
        a_if.ex_valid     = 1'b1;
        a_if.ex_mem_req   = mem;
        a_if.ex_is_load   = ld;
        a_if.ex_ld_size   = sz;
        a_if.ex_ld_signed = sgn;
        a_if.ex_addr_lo   = lo;
        a_if.ex_gr_we     = we;
        a_if.ex_dest      = dst;
        a_if.ex_result    = res;
    endtask

    task automatic set_ex64(input logic [1:0] sz, input logic sgn, input logic [2:0] lo);
        b_if.ex_valid     = 1'b1;
        b_if.ex_mem_req   = 1'b1;
        b_if.ex_is_load   = 1'b1;
        b_if.ex_ld_size   = sz;
        b_if.ex_ld_signed = sgn;
        b_if.ex_addr_lo   = lo;
        b_if.ex_gr_we     = 1'b1;
        b_if.ex_dest      = 5'd10;
        b_if.ex_result    = 64'd0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        {a_if.ex_valid, a_if.ex_mem_req, a_if.ex_is_load, a_if.ex_ld_signed} = '0;
        {a_if.ex_gr_we, a_if.data_ok, a_if.flush, a_if.flush_ex_req} = '0;
        a_if.ex_payload = '0; a_if.ex_result = '0; a_if.ex_ld_size = '0;
        a_if.ex_addr_lo = '0; a_if.ex_dest = '0; a_if.rdata = '0; a_if.wb_ready = 1'b1;
        {b_if.ex_valid, b_if.ex_mem_req, b_if.ex_is_load, b_if.ex_ld_signed} = '0;
        {b_if.ex_gr_we, b_if.data_ok, b_if.flush, b_if.flush_ex_req} = '0;
        b_if.ex_payload = '0; b_if.ex_result = '0; b_if.ex_ld_size = '0;
        b_if.ex_addr_lo = '0; b_if.ex_dest = '0; b_if.rdata = '0; b_if.wb_ready = 1'b1;

        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_wb_valid",    64'(a_if.wb_valid),    64'd0);
        chk("rst_ex_ready",    64'(a_if.ex_ready),    64'd1);
        chk("rst_req_allow",   64'(a_if.req_allow),   64'd1);
        chk("rst_fwd_data_ok", 64'(a_if.fwd_data_ok), 64'd1);
        chk("rst_wb_result",   64'(a_if.wb_result),   64'd0);
        chk("rst_fwd_dest",    64'(a_if.fwd_dest),    64'd0);

        // Signed byte load at offset 3, response two cycles late
        set_ex32(1'b1, 1'b1, 2'd0, 1'b1, 2'd3, 1'b1, 5'd5, 32'h1000);
        a_if.ex_payload = 128'hAB;
        #1;
        chk("lb_ex_ready", 64'(a_if.ex_ready), 64'd1);
        tick();
        a_if.ex_valid = 1'b0;
        #1;
        chk("lb_wait1_wb_valid", 64'(a_if.wb_valid),    64'd0);
        chk("lb_wait1_fwd_ok",   64'(a_if.fwd_data_ok), 64'd0);
        chk("lb_wait1_fwd_dest", 64'(a_if.fwd_dest),    64'd5);
        chk("lb_wait1_req_allow",64'(a_if.req_allow),   64'd1);
        tick();
        chk("lb_wait2_fwd_ok",   64'(a_if.fwd_data_ok), 64'd0);
        chk("lb_wait2_ex_ready", 64'(a_if.ex_ready),    64'd0);
        tick();
        a_if.data_ok = 1'b1;
        a_if.rdata   = 32'h80FF_1234;
        #1;
        chk("lb_wb_valid",   64'(a_if.wb_valid),    64'd1);
        chk("lb_wb_result",  64'(a_if.wb_result),   64'h0000_0000_FFFF_FF80);
        chk("lb_fwd_ok",     64'(a_if.fwd_data_ok), 64'd1);
        chk("lb_fwd_data",   64'(a_if.fwd_data),    64'h0000_0000_FFFF_FF80);
        chk("lb_wb_dest",    64'(a_if.wb_dest),     64'd5);
        chk("lb_wb_payload", 64'(a_if.wb_payload),  64'hAB);
        tick();
        a_if.data_ok = 1'b0;
        #1;
        chk("lb_after_wb_valid", 64'(a_if.wb_valid), 64'd0);

        // Signed half at offset 2 under three cycles of WB backpressure
        set_ex32(1'b1, 1'b1, 2'd1, 1'b1, 2'd2, 1'b1, 5'd7, 32'h0);
        tick();
        a_if.ex_valid = 1'b0;
        a_if.data_ok  = 1'b1;
        a_if.rdata    = 32'h8001_1234;
        a_if.wb_ready = 1'b0;
        #1;
        chk("bp_wb_valid0",  64'(a_if.wb_valid),  64'd1);
        chk("bp_wb_result0", 64'(a_if.wb_result), 64'h0000_0000_FFFF_8001);
        chk("bp_ex_ready0",  64'(a_if.ex_ready),  64'd0);
        tick();
        a_if.data_ok = 1'b0;
        a_if.rdata   = 32'hDEAD_BEEF;
        #1;
        chk("bp_wb_valid1",  64'(a_if.wb_valid),  64'd1);
        chk("bp_wb_result1", 64'(a_if.wb_result), 64'h0000_0000_FFFF_8001);
        chk("bp_req_allow1", 64'(a_if.req_allow), 64'd1);
        tick();
        chk("bp_wb_result2", 64'(a_if.wb_result), 64'h0000_0000_FFFF_8001);
        tick();
        a_if.wb_ready = 1'b1;
        #1;
        chk("bp_wb_valid3",  64'(a_if.wb_valid),  64'd1);
        chk("bp_wb_result3", 64'(a_if.wb_result), 64'h0000_0000_FFFF_8001);
        chk("bp_ex_ready3",  64'(a_if.ex_ready),  64'd1);
        tick();
        chk("bp_after_wb_valid", 64'(a_if.wb_valid), 64'd0);

        // Flush a pending load plus an accepted EX request: two orphans
        set_ex32(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b1, 5'd3, 32'h0);
        tick();
        a_if.ex_valid     = 1'b0;
        a_if.flush        = 1'b1;
        a_if.flush_ex_req = 1'b1;
        tick();
        a_if.flush        = 1'b0;
        a_if.flush_ex_req = 1'b0;
        a_if.data_ok      = 1'b1;
        a_if.rdata        = 32'h1111_1111;
        #1;
        chk("fl_req_allow_cnt2", 64'(a_if.req_allow), 64'd0);
        chk("fl_wb_valid_drop1", 64'(a_if.wb_valid),  64'd0);
        chk("fl_ex_ready",       64'(a_if.ex_ready),  64'd1);
        tick();
        set_ex32(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b1, 5'd9, 32'h0);
        a_if.rdata = 32'h2222_2222;
        #1;
        chk("fl_req_allow_cnt1", 64'(a_if.req_allow), 64'd1);
        tick();
        a_if.ex_valid = 1'b0;
        a_if.data_ok  = 1'b0;
        #1;
        chk("fl_new_wb_valid", 64'(a_if.wb_valid),    64'd0);
        chk("fl_new_req_allow",64'(a_if.req_allow),   64'd1);
        chk("fl_new_fwd_ok",   64'(a_if.fwd_data_ok), 64'd0);
        tick();
        a_if.data_ok = 1'b1;
        a_if.rdata   = 32'h1122_3344;
        #1;
        chk("fl_new_wb_valid_ok", 64'(a_if.wb_valid),  64'd1);
        chk("fl_new_wb_result",   64'(a_if.wb_result), 64'h0000_0000_1122_3344);
        chk("fl_new_wb_dest",     64'(a_if.wb_dest),   64'd9);
        tick();
        a_if.data_ok = 1'b0;
        #1;
        chk("fl_after_wb_valid", 64'(a_if.wb_valid), 64'd0);

        // Flush coincident with the consuming response: no orphan recorded
        set_ex32(1'b1, 1'b1, 2'd0, 1'b0, 2'd1, 1'b1, 5'd4, 32'h0);
        tick();
        a_if.ex_valid = 1'b0;
        a_if.flush    = 1'b1;
        a_if.data_ok  = 1'b1;
        a_if.rdata    = 32'hFFFF_FFFF;
        tick();
        a_if.flush   = 1'b0;
        a_if.data_ok = 1'b0;
        #1;
        chk("fc_wb_valid",  64'(a_if.wb_valid),  64'd0);
        chk("fc_req_allow", 64'(a_if.req_allow), 64'd1);
        set_ex32(1'b1, 1'b1, 2'd0, 1'b0, 2'd1, 1'b1, 5'd4, 32'h0);
        tick();
        a_if.ex_valid = 1'b0;
        a_if.data_ok  = 1'b1;
        a_if.rdata    = 32'h0000_AB00;
        #1;
        chk("fc_lbu_wb_valid",  64'(a_if.wb_valid),  64'd1);
        chk("fc_lbu_wb_result", 64'(a_if.wb_result), 64'h0000_0000_0000_00AB);
        tick();
        a_if.data_ok = 1'b0;

        // Store without register write still waits for its response
        set_ex32(1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 5'd6, 32'h77);
        tick();
        a_if.ex_valid = 1'b0;
        #1;
        chk("st_wb_valid_wait", 64'(a_if.wb_valid),    64'd0);
        chk("st_fwd_ok",        64'(a_if.fwd_data_ok), 64'd1);
        chk("st_fwd_dest",      64'(a_if.fwd_dest),    64'd0);
        tick();
        a_if.data_ok = 1'b1;
        #1;
        chk("st_wb_valid",  64'(a_if.wb_valid),  64'd1);
        chk("st_wb_result", 64'(a_if.wb_result), 64'h77);
        tick();
        a_if.data_ok = 1'b0;

        // Back-to-back ALU stream, then reset mid-stream
        for (int i = 0; i < 5; i++) begin
            set_ex32(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
            #1;
            chk("alu_ex_ready", 64'(a_if.ex_ready), 64'd1);
            if (i > 0) begin
                chk("alu_wb_valid",  64'(a_if.wb_valid),  64'd1);
                chk("alu_wb_result", 64'(a_if.wb_result), 64'h100 + 64'(i - 1));
            end
            tick();
        end
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        a_if.ex_valid = 1'b0;
        #1;
        chk("alu_rst_wb_valid", 64'(a_if.wb_valid), 64'd0);
        chk("alu_rst_ex_ready", 64'(a_if.ex_ready), 64'd1);

        // XLEN=64: dword, unsigned half at offset 6, signed word
        set_ex64(2'd3, 1'b0, 3'd0);
        tick();
        b_if.ex_valid = 1'b0;
        b_if.data_ok  = 1'b1;
        b_if.rdata    = 64'h0123_4567_89AB_CDEF;
        #1;
        chk("ld_wb_valid",  64'(b_if.wb_valid), 64'd1);
        chk("ld_wb_result", b_if.wb_result,     64'h0123_4567_89AB_CDEF);
        tick();
        b_if.data_ok = 1'b0;
        set_ex64(2'd1, 1'b0, 3'd6);
        tick();
        b_if.ex_valid = 1'b0;
        b_if.data_ok  = 1'b1;
        #1;
        chk("lhu6_wb_result", b_if.wb_result, 64'h0000_0000_0000_0123);
        tick();
        b_if.data_ok = 1'b0;
        set_ex64(2'd2, 1'b1, 3'd0);
        tick();
        b_if.ex_valid = 1'b0;
        b_if.data_ok  = 1'b1;
        #1;
        chk("lw_wb_result", b_if.wb_result, 64'hFFFF_FFFF_89AB_CDEF);
        tick();
        b_if.data_ok = 1'b0;
        #1;
        chk("lw_after_wb_valid", 64'(b_if.wb_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
